// File: rtl/clock_gen_nch.sv
// clock_gen_nch: NCH independent programmable clock/strobe dividers.
// Each channel has a shadow config (written via cfg_we/cfg_ch) that is
// sanitised and copied to the active set while idle or at a period boundary,
// so a running waveform never changes shape mid-period.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped, clk_out=0, active config tracks shadow
// S_DELAY | phase delay after enable, counting down before first rise
// S_HIGH  | clk_out=1, counting down the high time
// S_LOW   | clk_out=0, counting down the low time; cnt=0 is the boundary
module clock_gen_nch #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 2,
  parameter int DEF_HIGH   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   enable,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   running
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{period: CNT_W'(DEF_PERIOD),
                               high:   CNT_W'(DEF_HIGH),
                               phase:  '0};

  // Clamp a raw config so that high and low times are both at least one cycle
  // and the phase delay stays shorter than one period.
  function automatic cfg_t sanitise(input cfg_t c);
    cfg_t r;
    r = c;
    if (r.period < CNT_W'(2)) r.period = CNT_W'(2);
    if (r.high == '0) r.high = CNT_W'(1);
    if (r.high >= r.period) r.high = r.period - CNT_W'(1);
    if (r.phase >= r.period) r.phase = r.period - CNT_W'(1);
    return r;
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] act_period_q;
    logic [CNT_W-1:0] act_high_q;
    logic             clk_out_q;
    logic             tick_q;
    cfg_t             shadow_q;
    cfg_t             shadow_san;
    logic             wr_hit;

    // Indices >= NCH never match any channel, so such writes are dropped.
    assign wr_hit     = cfg_we && (cfg_ch == 4'(g));
    assign shadow_san = sanitise(shadow_q);

    // Shadow config register, written by the config port at any time.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q <= DEF_CFG;
      end else if (wr_hit) begin
        shadow_q <= '{period: cfg_period, high: cfg_high, phase: cfg_phase};
      end
    end

    // Channel FSM with down-counter; outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q      <= S_IDLE;
        cnt_q        <= '0;
        act_period_q <= CNT_W'(DEF_PERIOD);
        act_high_q   <= CNT_W'(DEF_HIGH);
        clk_out_q    <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            act_period_q <= shadow_san.period;
            act_high_q   <= shadow_san.high;
            if (enable[g]) begin
              if (shadow_san.phase == '0) begin
                state_q   <= S_HIGH;
                cnt_q     <= shadow_san.high - CNT_W'(1);
                clk_out_q <= 1'b1;
                tick_q    <= 1'b1;
              end else begin
                state_q <= S_DELAY;
                cnt_q   <= shadow_san.phase - CNT_W'(1);
              end
            end
          end
          S_DELAY: begin
            if (!enable[g]) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == '0) begin
              state_q   <= S_HIGH;
              cnt_q     <= act_high_q - CNT_W'(1);
              clk_out_q <= 1'b1;
              tick_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_HIGH: begin
            if (cnt_q == '0) begin
              state_q   <= S_LOW;
              cnt_q     <= act_period_q - act_high_q - CNT_W'(1);
              clk_out_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_LOW: begin
            if (cnt_q == '0) begin
              // Period boundary: take whatever the shadow held before this edge.
              act_period_q <= shadow_san.period;
              act_high_q   <= shadow_san.high;
              if (enable[g]) begin
                state_q   <= S_HIGH;
                cnt_q     <= shadow_san.high - CNT_W'(1);
                clk_out_q <= 1'b1;
                tick_q    <= 1'b1;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
          end
        endcase
      end
    end

    assign clk_out[g] = clk_out_q;
    assign tick[g]    = tick_q;
    assign running[g] = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_clock_gen_nch.sv
// Directed bench for clock_gen_nch: basic divide, phase/duty, stop, clamping
// and shadow timing, mid-run reset, and a long multi-channel run.
module tb_clock_gen_nch;

  localparam int NCH = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  enable;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic [15:0] cfg_phase;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  running;

  int checks = 0;
  int errors = 0;

  clock_gen_nch #(.NCH(NCH), .CNT_W(16), .DEF_PERIOD(2), .DEF_HIGH(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] ch, input int p, input int h, input int ph);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(ph);
    step();
    cfg_we     = 1'b0;
  endtask

  int          t5_hi [16] = '{1, 3, 5, 6, 7, 8, 9, 11, 12, 13, 14, 15, 17, 18, 20, 21};
  logic [22:0] t5_exp;
  int          t6_p  [4]  = '{7, 5, 9, 4};
  int          t6_h  [4]  = '{3, 2, 4, 3};
  int          t6_ph [4]  = '{4, 0, 8, 1};
  int          t6_n  [4]  = '{0, 3, 7, 11};

  initial begin
    logic [3:0] e_clk, e_tick, e_run;
    int t;

    rst = 1'b1; enable = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    step(); step();
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_tick",    32'(tick),    32'h0);
    chk("reset_running", 32'(running), 32'h0);
    rst = 1'b0;
    step();

    // T2: ch0 period 4, high 1, phase 0
    cfg_write(4'd0, 4, 1, 0);
    enable[0] = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      if (j == 13) enable[0] = 1'b0;
      step();
      e_clk = ((j <= 12) && ((j - 1) % 4 == 0)) ? 4'b0001 : 4'b0000;
      chk("t2_clk_out", 32'(clk_out), 32'(e_clk));
      chk("t2_tick",    32'(tick),    32'(e_clk));
      chk("t2_running", 32'(running), (j <= 12) ? 32'h1 : 32'h0);
    end

    // T3/T4: ch1 period 5, high 3, phase 2; drop enable in 2nd high cycle
    cfg_write(4'd1, 5, 3, 2);
    enable[1] = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      if (j == 15) enable[1] = 1'b0;
      step();
      t = j - 3;
      e_clk  = (j <= 17 && t >= 0 && (t % 5) < 3)  ? 4'b0010 : 4'b0000;
      e_tick = (j <= 17 && t >= 0 && (t % 5) == 0) ? 4'b0010 : 4'b0000;
      chk("t3_clk_out", 32'(clk_out), 32'(e_clk));
      chk("t3_tick",    32'(tick),    32'(e_tick));
      chk("t4_running", 32'(running), (j <= 17) ? 32'h2 : 32'h0);
    end

    // T5: clamped config, mid-period write, then a write in the boundary cycle
    t5_exp = '0;
    foreach (t5_hi[k]) t5_exp[t5_hi[k]] = 1'b1;
    cfg_write(4'd2, 1, 0, 0);
    enable[2] = 1'b1;
    for (int j = 1; j <= 23; j++) begin
      if (j == 4) begin
        cfg_we = 1'b1; cfg_ch = 4'd2;
        cfg_period = 16'd6; cfg_high = 16'd6; cfg_phase = 16'd0;
      end
      if (j == 5) cfg_we = 1'b0;
      if (j == 11) begin
        cfg_we = 1'b1; cfg_ch = 4'd2;
        cfg_period = 16'd3; cfg_high = 16'd2; cfg_phase = 16'd0;
      end
      if (j == 12) cfg_we = 1'b0;
      if (j == 23) enable[2] = 1'b0;
      step();
      if (j <= 22) begin
        e_clk  = t5_exp[j] ? 4'b0100 : 4'b0000;
        e_tick = (t5_exp[j] && !t5_exp[j-1]) ? 4'b0100 : 4'b0000;
        chk("t5_clk_out", 32'(clk_out), 32'(e_clk));
        chk("t5_tick",    32'(tick),    32'(e_tick));
      end else begin
        chk("t5_stop_running", 32'(running), 32'h0);
      end
    end

    // T1: reset in the middle of activity on all channels
    enable = 4'b1111;
    for (int j = 0; j < 7; j++) step();
    chk("t1_pre_running", 32'(running), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_clk_out", 32'(clk_out), 32'h0);
    chk("t1_tick",    32'(tick),    32'h0);
    chk("t1_running", 32'(running), 32'h0);
    enable = 4'b0001;
    step();
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      e_clk = (j % 2 == 1) ? 4'b0001 : 4'b0000;
      chk("t1_post_clk_out", 32'(clk_out), 32'(e_clk));
      chk("t1_post_tick",    32'(tick),    32'(e_clk));
    end
    enable = '0;
    step(); step();
    chk("t1_idle", 32'(running), 32'h0);

    // T6: all channels, distinct configs, staggered enables; ch 9 write ignored
    for (int i = 0; i < NCH; i++) cfg_write(4'(i), t6_p[i], t6_h[i], t6_ph[i]);
    cfg_write(4'd9, 3, 1, 0);
    step();
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NCH; i++) if (c == t6_n[i]) enable[i] = 1'b1;
      step();
      for (int i = 0; i < NCH; i++) begin
        t = c - t6_n[i] - t6_ph[i];
        e_clk[i]  = (t >= 0) && ((t % t6_p[i]) < t6_h[i]);
        e_tick[i] = (t >= 0) && ((t % t6_p[i]) == 0);
        e_run[i]  = (c >= t6_n[i]);
      end
      chk("t6_clk_out", 32'(clk_out), 32'(e_clk));
      chk("t6_tick",    32'(tick),    32'(e_tick));
      chk("t6_running", 32'(running), 32'(e_run));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
